// File: rtl/zpu_sd_bridge_if.sv
// hps_io side of the ZPU virtual-disk bridge: block requests, sector buffer port A, mount reports.
interface zpu_sd_bridge_if #(
    parameter int unsigned VDNUM  = 3,
    parameter int unsigned BUF_AW = 9
);
    logic [31:0]       sd_lba;
    logic [VDNUM-1:0]  sd_rd;
    logic [VDNUM-1:0]  sd_wr;
    logic              sd_ack;
    logic [BUF_AW-1:0] sd_buff_addr;
    logic [7:0]        sd_buff_dout;
    logic [7:0]        sd_buff_din;
    logic              sd_buff_wr;
    logic [VDNUM-1:0]  img_mounted;
    logic              img_readonly;
    logic [63:0]       img_size;

    // Bridge side: issues requests, serves buffer reads.
    modport master (
        output sd_lba, sd_rd, sd_wr, sd_buff_din,
        input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
        input  img_mounted, img_readonly, img_size
    );

    // hps_io side.
    modport slave (
        input  sd_lba, sd_rd, sd_wr, sd_buff_din,
        output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
        output img_mounted, img_readonly, img_size
    );
endinterface

// File: rtl/zpu_sd_bridge.sv
// Bridge between ZPU firmware I/O registers and the hps_io virtual-disk interface:
// sector buffer, per-drive block requests with watchdog, and a per-drive mount-event queue.
module zpu_sd_bridge #(
    parameter int unsigned VDNUM      = 3,
    parameter int unsigned BUF_AW     = 9,
    parameter int unsigned TMO_W      = 24,
    parameter logic [23:0] FILENO_MAP = 24'o76543410,
    parameter logic [7:0]  RO_MASK    = 8'b0000_0100
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        zpu_sel_lba,
    input  logic        zpu_block_rd,
    input  logic        zpu_block_wr,
    input  logic [2:0]  zpu_drv,
    input  logic        zpu_io_wr,
    input  logic        zpu_data_wr,
    input  logic        zpu_data_rd,
    input  logic [31:0] zpu_wdata,
    output logic [31:0] zpu_rdata,
    output logic [7:0]  zpu_status,
    output logic        zpu_error,
    input  logic        zpu_mount_ack,
    input  logic [1:0]  file_type,
    zpu_sd_bridge_if.master sd
);
    localparam int unsigned DEPTH = 1 << BUF_AW;
    localparam int unsigned E_RD  = 0;
    localparam int unsigned E_WR  = 1;
    localparam int unsigned E_DW  = 2;
    localparam int unsigned E_DR  = 3;
    // Last watchdog value before expiry: request lives 2^TMO_W-1 cycles.
    localparam logic [TMO_W-1:0] WD_LAST = ~TMO_W'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_XFER} state_t;

    state_t            state_q, state_d;
    logic [3:0]        edg_q, edg_d, edg_prev_q, edg_prev_d;
    logic              io_wr_q, io_wr_d, sel_lba_q, sel_lba_d;
    logic [2:0]        drv_q, drv_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              rd_rise, wr_rise, dw_rise, dr_fall, buf_we;

    logic [BUF_AW-1:0] ptr_q, ptr_d;
    logic              buf_wr_q, buf_wr_d;
    logic [7:0]        mem [DEPTH];
    logic [7:0]        q_a_q, q_a_d, q_b_q, q_b_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [31:0]       lba_q, lba_d;
    logic [VDNUM-1:0]  sd_rd_q, sd_rd_d, sd_wr_q, sd_wr_d;
    logic              ack_q, ack_d, io_done_q, io_done_d, error_q, error_d;
    logic [TMO_W-1:0]  wd_q, wd_d;
    logic              req_bad;

    logic [VDNUM-1:0]  mnt_prev_q, mnt_prev_d, pend_q, pend_d, mnt_rise;
    logic [31:0]       size_q [VDNUM];
    logic [31:0]       size_d [VDNUM];
    logic [1:0]        type_q [VDNUM];
    logic [1:0]        type_d [VDNUM];
    logic [VDNUM-1:0]  ro_q, ro_d;
    logic              presented_q, presented_d, toggle_q, toggle_d;
    logic [31:0]       p_size_q, p_size_d;
    logic [2:0]        p_fileno_q, p_fileno_d;
    logic [1:0]        p_type_q, p_type_d;
    logic              p_ro_q, p_ro_d;
    logic [VDNUM-1:0]  pick_oh;
    logic [31:0]       pick_size;
    logic [2:0]        pick_fileno;
    logic [1:0]        pick_type;
    logic              pick_ro;
    logic              unused_hi;

    assign rd_rise  = edg_q[E_RD] & ~edg_prev_q[E_RD];
    assign wr_rise  = edg_q[E_WR] & ~edg_prev_q[E_WR];
    assign dw_rise  = edg_q[E_DW] & ~edg_prev_q[E_DW];
    assign dr_fall  = ~edg_q[E_DR] & edg_prev_q[E_DR];
    assign buf_we   = dw_rise & ~sel_lba_q;
    assign mnt_rise = sd.img_mounted & ~mnt_prev_q;
    assign unused_hi = ^sd.img_size[63:32];

    assign zpu_rdata       = rdata_q;
    assign zpu_status      = {p_ro_q, p_type_q, p_fileno_q, toggle_q, io_done_q};
    assign zpu_error       = error_q;
    assign sd.sd_lba       = lba_q;
    assign sd.sd_rd        = sd_rd_q;
    assign sd.sd_wr        = sd_wr_q;
    assign sd.sd_buff_din  = q_a_q;

    // Input stages, buffer pointer and read-data muxing.
    always_comb begin
        edg_d      = {zpu_data_rd, zpu_data_wr, zpu_block_wr, zpu_block_rd};
        edg_prev_d = edg_q;
        io_wr_d    = zpu_io_wr;
        sel_lba_d  = zpu_sel_lba;
        drv_d      = zpu_drv;
        wdata_d    = zpu_wdata;
        buf_wr_d   = buf_we;
        ptr_d      = ptr_q;
        if (io_wr_q) begin
            ptr_d = '0;
        end else if (buf_wr_q || dr_fall) begin
            ptr_d = ptr_q + BUF_AW'(1);
        end
        q_a_d   = mem[sd.sd_buff_addr];
        q_b_d   = mem[ptr_q];
        rdata_d = sel_lba_q ? p_size_q : {24'h0, q_b_q};
    end

    // Request FSM with watchdog.
    always_comb begin
        state_d   = state_q;
        lba_d     = lba_q;
        sd_rd_d   = sd_rd_q;
        sd_wr_d   = sd_wr_q;
        io_done_d = io_done_q;
        error_d   = error_q;
        wd_d      = wd_q;
        ack_d     = sd.sd_ack;
        req_bad   = (rd_rise && wr_rise) || (32'(drv_q) >= VDNUM);
        case (state_q)
            ST_IDLE: begin
                if (dw_rise && sel_lba_q) begin
                    lba_d = wdata_q;
                end
                if (rd_rise || wr_rise) begin
                    io_done_d = 1'b0;
                    error_d   = 1'b0;
                    if (req_bad) begin
                        io_done_d = 1'b1;
                        error_d   = 1'b1;
                    end else begin
                        if (rd_rise) begin
                            sd_rd_d = VDNUM'(1) << drv_q;
                        end else begin
                            sd_wr_d = VDNUM'(1) << drv_q;
                        end
                        wd_d    = '0;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ, ST_XFER: begin
                wd_d = wd_q + TMO_W'(1);
                if (wd_q == WD_LAST) begin
                    sd_rd_d   = '0;
                    sd_wr_d   = '0;
                    io_done_d = 1'b1;
                    error_d   = 1'b1;
                    state_d   = ST_IDLE;
                end else if (state_q == ST_REQ) begin
                    if (sd.sd_ack) begin
                        sd_rd_d = '0;
                        sd_wr_d = '0;
                        state_d = ST_XFER;
                    end
                end else if (ack_q && !sd.sd_ack) begin
                    io_done_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Mount-event queue: capture per drive, present lowest pending drive.
    always_comb begin
        mnt_prev_d  = sd.img_mounted;
        pend_d      = pend_q;
        size_d      = size_q;
        type_d      = type_q;
        ro_d        = ro_q;
        presented_d = presented_q;
        toggle_d    = toggle_q;
        p_size_d    = p_size_q;
        p_fileno_d  = p_fileno_q;
        p_type_d    = p_type_q;
        p_ro_d      = p_ro_q;
        pick_oh     = '0;
        pick_size   = '0;
        pick_fileno = '0;
        pick_type   = '0;
        pick_ro     = 1'b0;
        for (int i = int'(VDNUM) - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                pick_oh     = '0;
                pick_oh[i]  = 1'b1;
                pick_size   = size_q[i];
                pick_fileno = FILENO_MAP[3*i +: 3];
                pick_type   = type_q[i];
                pick_ro     = ro_q[i];
            end
        end
        if (zpu_mount_ack) begin
            presented_d = 1'b0;
        end
        if (!presented_q && pend_q != '0) begin
            pend_d      = pend_q & ~pick_oh;
            toggle_d    = ~toggle_q;
            presented_d = 1'b1;
            p_size_d    = pick_size;
            p_fileno_d  = pick_fileno;
            p_type_d    = pick_type;
            p_ro_d      = pick_ro;
        end
        // A fresh edge wins over the same-cycle clear so no event is lost.
        for (int i = 0; i < int'(VDNUM); i++) begin
            if (mnt_rise[i]) begin
                pend_d[i] = 1'b1;
                size_d[i] = sd.img_size[31:0];
                ro_d[i]   = sd.img_readonly | RO_MASK[i];
                type_d[i] = file_type;
            end
        end
    end

    // Sector buffer storage: port A from hps_io, port B from the ZPU pointer.
    always_ff @(posedge clk_sys) begin
        if (sd.sd_buff_wr) begin
            mem[sd.sd_buff_addr] <= sd.sd_buff_dout;
        end
        if (buf_we) begin
            mem[ptr_q] <= wdata_q[7:0];
        end
    end

    // State registers.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            edg_q       <= '0;
            edg_prev_q  <= '0;
            io_wr_q     <= 1'b0;
            sel_lba_q   <= 1'b0;
            drv_q       <= '0;
            wdata_q     <= '0;
            ptr_q       <= '0;
            buf_wr_q    <= 1'b0;
            q_a_q       <= '0;
            q_b_q       <= '0;
            rdata_q     <= '0;
            lba_q       <= '0;
            sd_rd_q     <= '0;
            sd_wr_q     <= '0;
            ack_q       <= 1'b0;
            io_done_q   <= 1'b0;
            error_q     <= 1'b0;
            wd_q        <= '0;
            mnt_prev_q  <= '0;
            pend_q      <= '0;
            size_q      <= '{default: '0};
            type_q      <= '{default: '0};
            ro_q        <= '0;
            presented_q <= 1'b0;
            toggle_q    <= 1'b0;
            p_size_q    <= '0;
            p_fileno_q  <= '0;
            p_type_q    <= '0;
            p_ro_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            edg_q       <= edg_d;
            edg_prev_q  <= edg_prev_d;
            io_wr_q     <= io_wr_d;
            sel_lba_q   <= sel_lba_d;
            drv_q       <= drv_d;
            wdata_q     <= wdata_d;
            ptr_q       <= ptr_d;
            buf_wr_q    <= buf_wr_d;
            q_a_q       <= q_a_d;
            q_b_q       <= q_b_d;
            rdata_q     <= rdata_d;
            lba_q       <= lba_d;
            sd_rd_q     <= sd_rd_d;
            sd_wr_q     <= sd_wr_d;
            ack_q       <= ack_d;
            io_done_q   <= io_done_d;
            error_q     <= error_d;
            wd_q        <= wd_d;
            mnt_prev_q  <= mnt_prev_d;
            pend_q      <= pend_d;
            size_q      <= size_d;
            type_q      <= type_d;
            ro_q        <= ro_d;
            presented_q <= presented_d;
            toggle_q    <= toggle_d;
            p_size_q    <= p_size_d;
            p_fileno_q  <= p_fileno_d;
            p_type_q    <= p_type_d;
            p_ro_q      <= p_ro_d;
        end
    end
endmodule

// File: tb/tb_zpu_sd_bridge.sv
// Randomized self-checking bench for zpu_sd_bridge with a behavioural buffer/mount model.
module tb_zpu_sd_bridge;
    localparam int unsigned VDNUM  = 3;
    localparam int unsigned BUF_AW = 9;
    localparam int unsigned TMO_W  = 10;
    localparam int unsigned DEPTH  = 512;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        zpu_sel_lba = 1'b0;
    logic        zpu_block_rd = 1'b0;
    logic        zpu_block_wr = 1'b0;
    logic [2:0]  zpu_drv = 3'd0;
    logic        zpu_io_wr = 1'b0;
    logic        zpu_data_wr = 1'b0;
    logic        zpu_data_rd = 1'b0;
    logic [31:0] zpu_wdata = 32'd0;
    logic [31:0] zpu_rdata;
    logic [7:0]  zpu_status;
    logic        zpu_error;
    logic        zpu_mount_ack = 1'b0;
    logic [1:0]  file_type = 2'd0;

    int total = 0;
    int bad = 0;

    // Reference model state
    logic [7:0]  mem_m [DEPTH];
    int          ptr_m = 0;
    logic [31:0] lba_m = 32'd0;
    logic [2:0]  pend_m = 3'b000;
    logic [31:0] size_m [3];
    logic        ro_m [3];
    logic [1:0]  type_m [3];
    logic        toggle_m = 1'b0;
    int          fno_m [3] = '{0, 1, 4};

    zpu_sd_bridge_if #(.VDNUM(VDNUM), .BUF_AW(BUF_AW)) sd_if ();

    zpu_sd_bridge #(.VDNUM(VDNUM), .BUF_AW(BUF_AW), .TMO_W(TMO_W)) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .zpu_sel_lba   (zpu_sel_lba),
        .zpu_block_rd  (zpu_block_rd),
        .zpu_block_wr  (zpu_block_wr),
        .zpu_drv       (zpu_drv),
        .zpu_io_wr     (zpu_io_wr),
        .zpu_data_wr   (zpu_data_wr),
        .zpu_data_rd   (zpu_data_rd),
        .zpu_wdata     (zpu_wdata),
        .zpu_rdata     (zpu_rdata),
        .zpu_status    (zpu_status),
        .zpu_error     (zpu_error),
        .zpu_mount_ack (zpu_mount_ack),
        .file_type     (file_type),
        .sd            (sd_if)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic mount_pulse(input logic [2:0] mask, input logic [31:0] size,
                               input logic ro, input logic [1:0] ft);
        sd_if.img_mounted  = mask;
        sd_if.img_readonly = ro;
        sd_if.img_size     = {32'($urandom), size};
        file_type          = ft;
        tick(1);
        sd_if.img_mounted  = 3'b000;
        tick(1);
        for (int i = 0; i < 3; i++) begin
            if (mask[i]) begin
                pend_m[i] = 1'b1;
                size_m[i] = size;
                ro_m[i]   = ro | (i == 2);
                type_m[i] = ft;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(3);
        total++;
        if ({zpu_rdata, zpu_status, zpu_error} !== 41'd0) begin
            bad++;
            $display("FAIL reset_zpu got=%0h want=0", {zpu_rdata, zpu_status, zpu_error});
        end
        total++;
        if ({sd_if.sd_lba, sd_if.sd_rd, sd_if.sd_wr, sd_if.sd_buff_din} !== 46'd0) begin
            bad++;
            $display("FAIL reset_sd got=%0h want=0",
                     {sd_if.sd_lba, sd_if.sd_rd, sd_if.sd_wr, sd_if.sd_buff_din});
        end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_buffer_roundtrip;
        logic [7:0] vals [8];
        vals[0] = 8'h11;
        vals[1] = 8'h22;
        for (int i = 2; i < 8; i++) vals[i] = 8'($urandom);
        zpu_sel_lba = 1'b0;
        zpu_io_wr = 1'b1; tick(2); zpu_io_wr = 1'b0; tick(2);
        ptr_m = 0;
        for (int i = 0; i < 8; i++) begin
            zpu_wdata = {24'($urandom), vals[i]};
            zpu_data_wr = 1'b1; tick(1); zpu_data_wr = 1'b0; tick(3);
            mem_m[ptr_m] = vals[i];
            ptr_m = (ptr_m + 1) % DEPTH;
        end
        zpu_io_wr = 1'b1; tick(2); zpu_io_wr = 1'b0; tick(5);
        ptr_m = 0;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (zpu_rdata !== {24'h0, mem_m[ptr_m]}) begin
                bad++;
                $display("FAIL rt_zpu_read[%0d] got=%0h want=%0h", i, zpu_rdata, mem_m[ptr_m]);
            end
            zpu_data_rd = 1'b1; tick(1); zpu_data_rd = 1'b0; tick(5);
            ptr_m = (ptr_m + 1) % DEPTH;
        end
        for (int i = 0; i < 8; i++) begin
            sd_if.sd_buff_addr = 9'(i);
            tick(2);
            total++;
            if (sd_if.sd_buff_din !== vals[i]) begin
                bad++;
                $display("FAIL rt_porta[%0d] got=%0h want=%0h", i, sd_if.sd_buff_din, vals[i]);
            end
        end
    endtask

    task automatic test_sector_read;
        int n;
        lba_m = 32'h0000_1234;
        zpu_sel_lba = 1'b1; zpu_wdata = lba_m;
        zpu_data_wr = 1'b1; tick(1); zpu_data_wr = 1'b0; tick(3);
        zpu_sel_lba = 1'b0;
        zpu_drv = 3'd1; zpu_block_rd = 1'b1;
        n = 0;
        while (sd_if.sd_rd === 3'b000 && n < 10) begin tick(1); n++; end
        total++;
        if ({sd_if.sd_rd, sd_if.sd_wr} !== 6'b010_000) begin
            bad++;
            $display("FAIL sec_req got=%b want=010000", {sd_if.sd_rd, sd_if.sd_wr});
        end
        total++;
        if (sd_if.sd_lba !== lba_m || zpu_status[0] !== 1'b0) begin
            bad++;
            $display("FAIL sec_lba got=%0h/%b want=%0h/0", sd_if.sd_lba, zpu_status[0], lba_m);
        end
        sd_if.sd_ack = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            sd_if.sd_buff_wr   = 1'b1;
            sd_if.sd_buff_addr = 9'(i);
            sd_if.sd_buff_dout = 8'($urandom);
            mem_m[i] = sd_if.sd_buff_dout;
            tick(1);
        end
        sd_if.sd_buff_wr = 1'b0;
        total++;
        if (sd_if.sd_rd !== 3'b000) begin
            bad++;
            $display("FAIL sec_rd_drop got=%b want=000", sd_if.sd_rd);
        end
        sd_if.sd_ack = 1'b0;
        n = 0;
        while (zpu_status[0] !== 1'b1 && n < 20) begin tick(1); n++; end
        total++;
        if ({zpu_status[0], zpu_error} !== 2'b10) begin
            bad++;
            $display("FAIL sec_done got=%b want=10", {zpu_status[0], zpu_error});
        end
        zpu_block_rd = 1'b0;
        zpu_io_wr = 1'b1; tick(2); zpu_io_wr = 1'b0; tick(5);
        total++;
        if (zpu_rdata !== {24'h0, mem_m[0]}) begin
            bad++;
            $display("FAIL sec_byte0 got=%0h want=%0h", zpu_rdata, mem_m[0]);
        end
        for (int i = 0; i < 511; i++) begin
            zpu_data_rd = 1'b1; tick(1); zpu_data_rd = 1'b0; tick(1);
        end
        tick(5);
        total++;
        if (zpu_rdata !== {24'h0, mem_m[511]}) begin
            bad++;
            $display("FAIL sec_byte511 got=%0h want=%0h", zpu_rdata, mem_m[511]);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        logic [2:0] d;
        logic is_rd;
        logic [2:0] exp_oh;
        for (int k = 0; k < 4; k++) begin
            d = 3'($urandom_range(0, 2));
            is_rd = 1'($urandom);
            exp_oh = 3'b001 << d;
            zpu_drv = d;
            if (is_rd) zpu_block_rd = 1'b1; else zpu_block_wr = 1'b1;
            n = 0;
            while ((sd_if.sd_rd | sd_if.sd_wr) === 3'b000 && n < 10) begin tick(1); n++; end
            total++;
            if ({sd_if.sd_rd, sd_if.sd_wr, zpu_status[0]} !==
                {(is_rd ? exp_oh : 3'b000), (is_rd ? 3'b000 : exp_oh), 1'b0}) begin
                bad++;
                $display("FAIL b2b_req[%0d] got=%b want rd=%0b drv=%0d",
                         k, {sd_if.sd_rd, sd_if.sd_wr, zpu_status[0]}, is_rd, d);
            end
            sd_if.sd_ack = 1'b1; tick(3); sd_if.sd_ack = 1'b0;
            n = 0;
            while (zpu_status[0] !== 1'b1 && n < 20) begin tick(1); n++; end
            total++;
            if ({zpu_status[0], zpu_error, sd_if.sd_rd, sd_if.sd_wr} !== 8'b10_000_000) begin
                bad++;
                $display("FAIL b2b_done[%0d] got=%b want=10000000",
                         k, {zpu_status[0], zpu_error, sd_if.sd_rd, sd_if.sd_wr});
            end
            zpu_block_rd = 1'b0; zpu_block_wr = 1'b0; tick(3);
            if (k % 2 == 0) begin
                zpu_drv = 3'($urandom_range(3, 7));
                if (is_rd) zpu_block_wr = 1'b1; else zpu_block_rd = 1'b1;
            end else begin
                zpu_drv = 3'($urandom_range(0, 2));
                zpu_block_rd = 1'b1; zpu_block_wr = 1'b1;
            end
            tick(5);
            total++;
            if ({sd_if.sd_rd, sd_if.sd_wr, zpu_status[0], zpu_error} !== 8'b000_000_11) begin
                bad++;
                $display("FAIL illegal[%0d] got=%b want=00000011",
                         k, {sd_if.sd_rd, sd_if.sd_wr, zpu_status[0], zpu_error});
            end
            zpu_block_rd = 1'b0; zpu_block_wr = 1'b0; tick(3);
        end
    endtask

    task automatic test_timeout;
        int n;
        logic [2:0] d;
        d = 3'($urandom_range(0, 2));
        zpu_drv = d; zpu_block_wr = 1'b1;
        n = 0;
        while (sd_if.sd_wr === 3'b000 && n < 10) begin tick(1); n++; end
        total++;
        if (sd_if.sd_wr !== (3'b001 << d)) begin
            bad++;
            $display("FAIL tmo_req got=%b drv=%0d", sd_if.sd_wr, d);
        end
        n = 0;
        while (sd_if.sd_wr !== 3'b000 && n < 4000) begin
            if (n == 3) begin zpu_sel_lba = 1'b1; zpu_wdata = $urandom; zpu_data_wr = 1'b1; end
            if (n == 4) zpu_data_wr = 1'b0;
            tick(1);
            n++;
        end
        total++;
        if (n != (1 << TMO_W) - 1) begin
            bad++;
            $display("FAIL tmo_cycles got=%0d want=%0d", n, (1 << TMO_W) - 1);
        end
        total++;
        if ({zpu_status[0], zpu_error} !== 2'b11) begin
            bad++;
            $display("FAIL tmo_flags got=%b want=11", {zpu_status[0], zpu_error});
        end
        total++;
        if (sd_if.sd_lba !== lba_m) begin
            bad++;
            $display("FAIL tmo_lba_locked got=%0h want=%0h", sd_if.sd_lba, lba_m);
        end
        zpu_block_wr = 1'b0; zpu_sel_lba = 1'b0; tick(3);
    endtask

    task automatic test_mounts;
        int d;
        logic extra;
        logic [6:0] exp_st;
        zpu_sel_lba = 1'b1;
        for (int r = 0; r < 6; r++) begin
            if (r == 0) mount_pulse(3'b101, 32'd92176, 1'b0, 2'($urandom));
            else mount_pulse(3'($urandom_range(1, 7)), $urandom, 1'($urandom), 2'($urandom));
            tick(3);
            extra = (r % 2 == 1);
            while (pend_m != 3'b000) begin
                d = 0;
                for (int i = 2; i >= 0; i--) if (pend_m[i]) d = i;
                pend_m[d] = 1'b0;
                toggle_m = ~toggle_m;
                exp_st = {ro_m[d], type_m[d], 3'(fno_m[d]), toggle_m};
                total++;
                if (zpu_status[7:1] !== exp_st) begin
                    bad++;
                    $display("FAIL mount_status[%0d] got=%b want=%b drv=%0d",
                             r, zpu_status[7:1], exp_st, d);
                end
                total++;
                if (zpu_rdata !== size_m[d]) begin
                    bad++;
                    $display("FAIL mount_size[%0d] got=%0d want=%0d", r, zpu_rdata, size_m[d]);
                end
                if (extra) begin
                    extra = 1'b0;
                    mount_pulse(3'($urandom_range(1, 7)), $urandom, 1'($urandom), 2'($urandom));
                end
                zpu_mount_ack = 1'b1; tick(1); zpu_mount_ack = 1'b0; tick(3);
            end
        end
        zpu_sel_lba = 1'b0;
        tick(3);
    endtask

    task automatic test_reset_mid;
        int n;
        zpu_drv = 3'd0; zpu_block_rd = 1'b1;
        n = 0;
        while (sd_if.sd_rd === 3'b000 && n < 10) begin tick(1); n++; end
        sd_if.sd_ack = 1'b1; tick(3);
        reset = 1'b1; zpu_block_rd = 1'b0;
        tick(1);
        total++;
        if ({zpu_rdata, zpu_status, zpu_error, sd_if.sd_lba, sd_if.sd_rd, sd_if.sd_wr,
             sd_if.sd_buff_din} !== 87'd0) begin
            bad++;
            $display("FAIL rstmid_outputs got=%0h/%0h/%b/%0h/%b/%b want=0", zpu_rdata, zpu_status,
                     zpu_error, sd_if.sd_lba, sd_if.sd_rd, sd_if.sd_wr);
        end
        reset = 1'b0; tick(2);
        sd_if.sd_ack = 1'b0; tick(6);
        total++;
        if ({zpu_status[0], zpu_error, sd_if.sd_rd} !== 5'b00_000) begin
            bad++;
            $display("FAIL rstmid_no_done got=%b want=00000", {zpu_status[0], zpu_error, sd_if.sd_rd});
        end
    endtask

    initial begin
        sd_if.sd_ack       = 1'b0;
        sd_if.sd_buff_addr = '0;
        sd_if.sd_buff_dout = 8'd0;
        sd_if.sd_buff_wr   = 1'b0;
        sd_if.img_mounted  = 3'b000;
        sd_if.img_readonly = 1'b0;
        sd_if.img_size     = 64'd0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'd0;
        test_reset();
        test_buffer_roundtrip();
        test_sector_read();
        test_back_to_back();
        test_timeout();
        test_mounts();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
